// File: rtl/pid_pipe.sv
// Three-stage pipelined PID controller with clamped integrator,
// runtime-loadable gains and rounded, saturated output.
module pid_pipe #(
  parameter int DATA_W       = 8,
  parameter int GAIN_W       = 16,
  parameter int FRAC         = 10,
  parameter int OUT_W        = 16,
  parameter int INT_LIM      = 4096,
  parameter int INT_W        = 24,
  parameter int INT_UNSIGNED = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] refer,
  input  logic [DATA_W-1:0] data,
  input  logic [GAIN_W-1:0] k_p,
  input  logic [GAIN_W-1:0] k_i,
  input  logic [GAIN_W-1:0] k_d,
  input  logic              gain_load,
  input  logic              clear,
  output logic              out_valid,
  output logic [OUT_W-1:0]  control,
  output logic              sat
);

  localparam int EW = DATA_W + 1;
  localparam int DW = DATA_W + 2;
  localparam int AW = ((INT_W > EW) ? INT_W : EW) + 1;
  localparam int MW = (INT_W > DW) ? INT_W : DW;
  localparam int PW = MW + GAIN_W;
  localparam int SW = PW + 3;

  localparam logic signed [AW-1:0] LIM = AW'(INT_LIM);
  localparam logic signed [AW-1:0] LO =
    (INT_UNSIGNED != 0) ? AW'(0) : -LIM;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
  localparam logic signed [OUT_W-1:0] CMAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] CMIN = ~CMAX;

  logic signed [INT_W-1:0]  int_reg;
  logic signed [EW-1:0]     prev_e;
  logic signed [GAIN_W-1:0] gp, gi, gd;

  logic signed [EW-1:0]     e, pe_base;
  logic signed [INT_W-1:0]  i_base;
  logic signed [AW-1:0]     acc, i_cl;
  logic signed [DW-1:0]     d;

  logic                     v1, v2;
  logic signed [EW-1:0]     e1;
  logic signed [INT_W-1:0]  i1;
  logic signed [DW-1:0]     d1;
  logic signed [PW-1:0]     pp, pi, pd;
  logic signed [SW-1:0]     s, r;

  // clear makes this sample see an empty history
  assign e       = EW'($signed(refer)) - EW'($signed(data));
  assign i_base  = clear ? '0 : int_reg;
  assign pe_base = clear ? '0 : prev_e;
  assign acc     = AW'(i_base) + AW'(e);
  assign d       = DW'(e) - DW'(pe_base);

  always_comb begin
    i_cl = acc;
    if (acc > LIM)
      i_cl = LIM;
    else if (acc < LO)
      i_cl = LO;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gp <= '0;
      gi <= '0;
      gd <= '0;
    end else if (gain_load) begin
      gp <= $signed(k_p);
      gi <= $signed(k_i);
      gd <= $signed(k_d);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      e1      <= '0;
      i1      <= '0;
      d1      <= '0;
      int_reg <= '0;
      prev_e  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        e1      <= e;
        i1      <= INT_W'(i_cl);
        d1      <= d;
        int_reg <= INT_W'(i_cl);
        prev_e  <= e;
      end else if (clear) begin
        int_reg <= '0;
        prev_e  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2 <= 1'b0;
      pp <= '0;
      pi <= '0;
      pd <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        pp <= PW'(e1) * PW'(gp);
        pi <= PW'(i1) * PW'(gi);
        pd <= PW'(d1) * PW'(gd);
      end
    end
  end

  // arithmetic shift floors, so the offset rounds half toward +inf
  assign s = SW'(pp) + SW'(pi) + SW'(pd) + RND;
  assign r = s >>> FRAC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      control   <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        if (r > SW'(CMAX)) begin
          control <= CMAX;
          sat     <= 1'b1;
        end else if (r < SW'(CMIN)) begin
          control <= CMIN;
          sat     <= 1'b1;
        end else begin
          control <= OUT_W'(r);
          sat     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_pipe.sv
// Directed bench for pid_pipe: vector table plus hand sequences
// for streaming, gain timing, windup, unsigned integrator, reset.
module tb_pid_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, in_valid, gain_load, clear;
  logic [7:0]        refer, data;
  logic [15:0]       k_p, k_i, k_d;
  logic              out_valid, sat, out_valid2, sat2;
  logic signed [15:0] control, control2;

  int pass_cnt = 0;
  int total_cnt = 0;

  pid_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .refer(refer), .data(data),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .gain_load(gain_load), .clear(clear),
    .out_valid(out_valid), .control(control), .sat(sat)
  );

  pid_pipe #(.INT_UNSIGNED(1)) dut_u (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .refer(refer), .data(data),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .gain_load(gain_load), .clear(clear),
    .out_valid(out_valid2), .control(control2), .sat(sat2)
  );

  typedef struct {
    logic ld;
    int   gp, gi, gd;
    int   r, d;
    logic clr;
    int   ctl;
    logic st;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int gp, input int gi, input int gd);
    k_p = 16'(gp);
    k_i = 16'(gi);
    k_d = 16'(gd);
    gain_load = 1'b1;
    step;
    gain_load = 1'b0;
  endtask

  task automatic drive(input int r, input int d, input logic clr);
    in_valid = 1'b1;
    refer = 8'(r);
    data = 8'(d);
    clear = clr;
    step;
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    int seen;
    tbl[0]  = '{1, 1024, 0, 0, 10, 3, 1, 7, 0};
    tbl[1]  = '{0, 0, 0, 0, -5, 20, 1, -25, 0};
    tbl[2]  = '{1, 1536, 0, 0, 3, 0, 1, 5, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 3, 1, -4, 0};
    tbl[4]  = '{1, -1024, 0, 0, 127, 0, 1, -127, 0};
    tbl[5]  = '{1, 32767, 0, 0, 127, -128, 1, 8160, 0};
    tbl[6]  = '{1, 0, 512, 0, 4, 0, 1, 2, 0};
    tbl[7]  = '{0, 0, 0, 0, 4, 0, 0, 4, 0};
    tbl[8]  = '{0, 0, 0, 0, 6, 2, 0, 6, 0};
    tbl[9]  = '{1, 0, 0, 1024, 5, 0, 1, 5, 0};
    tbl[10] = '{0, 0, 0, 0, 5, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, -3, 0, 0, -8, 0};
    tbl[12] = '{1, 0, 32767, 0, 127, 0, 1, 4064, 0};
    tbl[13] = '{1, 32767, 32767, 32767, -128, 127, 1, -24479, 0};

    reset_n = 1'b0;
    in_valid = 1'b0;
    gain_load = 1'b0;
    clear = 1'b0;
    refer = '0;
    data = '0;
    k_p = '0;
    k_i = '0;
    k_d = '0;
    #2;
    chk("rst control", control, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst sat", sat, 0);
    step;
    step;
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].ld) load(tbl[i].gp, tbl[i].gi, tbl[i].gd);
      drive(tbl[i].r, tbl[i].d, tbl[i].clr);
      step;
      chk($sformatf("vec%0d early", i), out_valid, 0);
      step;
      chk($sformatf("vec%0d valid", i), out_valid, 1);
      chk($sformatf("vec%0d control", i), control, tbl[i].ctl);
      chk($sformatf("vec%0d sat", i), sat, tbl[i].st);
    end

    load(0, 512, 0);
    drive(4, 0, 1);
    drive(4, 0, 0);
    drive(4, 0, 0);
    chk("stream i0", control, 2);
    step;
    chk("stream i1", control, 4);
    step;
    chk("stream i2", control, 6);

    load(1024, 0, 0);
    drive(10, 0, 1);
    in_valid = 1'b1;
    refer = 8'd10;
    data = 8'd0;
    clear = 1'b1;
    k_p = 16'd2048;
    gain_load = 1'b1;
    step;
    in_valid = 1'b0;
    clear = 1'b0;
    gain_load = 1'b0;
    step;
    chk("gain old", control, 10);
    step;
    chk("gain new", control, 20);

    load(0, 32767, 0);
    drive(127, 0, 1);
    repeat (39) drive(127, 0, 0);
    chk("windup hi int", dut.int_reg, 4096);
    step;
    step;
    chk("windup hi ctl", control, 32767);
    chk("windup hi sat", sat, 1);
    drive(-128, 0, 0);
    chk("unwind int1", dut.int_reg, 3968);
    drive(-128, 0, 0);
    chk("unwind int2", dut.int_reg, 3840);
    step;
    step;
    chk("unwind ctl", control, 32767);
    drive(-128, 0, 1);
    repeat (39) drive(-128, 0, 0);
    chk("windup lo int", dut.int_reg, -4096);
    step;
    step;
    chk("windup lo ctl", control, -32768);
    chk("windup lo sat", sat, 1);
    drive(0, 0, 1);
    step;
    step;
    chk("unsat ctl", control, 0);
    chk("unsat sat", sat, 0);

    load(0, 1024, 0);
    drive(0, 50, 1);
    chk("uns int neg", dut_u.int_reg, 0);
    chk("sgn int neg", dut.int_reg, -50);
    step;
    step;
    chk("uns ctl neg", control2, 0);
    chk("sgn ctl neg", control, -50);
    drive(20, 0, 0);
    chk("uns int pos", dut_u.int_reg, 20);
    step;
    step;
    chk("uns ctl pos", control2, 20);
    drive(5, 0, 1);
    chk("uns int clr", dut_u.int_reg, 5);
    step;
    step;
    chk("uns ctl clr", control2, 5);
    chk("sgn ctl clr", control, 5);

    load(1024, 0, 0);
    drive(10, 0, 1);
    drive(10, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst control", control, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst int", dut.int_reg, 0);
    step;
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      step;
      seen += int'(out_valid);
    end
    chk("midrst ghost valid", seen, 0);
    drive(10, 0, 0);
    step;
    step;
    chk("postrst valid", out_valid, 1);
    chk("postrst gains zero", control, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
